// File: rtl/heap_pkg.sv
// Shared definitions for the top-K heap and its feed controller: word flag
// codes, sentinel word constructors, key comparators and the feeder states.
package heap_pkg;

    localparam int HEAP_DATA_W = 16;
    localparam int HEAP_KEY_W  = 4;

    // Two MSBs of every heap word carry a flag; only NORMAL is a real record.
    localparam logic [1:0] FLAG_NORMAL = 2'b00;
    localparam logic [1:0] FLAG_MIN    = 2'b01;
    localparam logic [1:0] FLAG_MAX    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_COLLECT,
        ST_BURST,
        ST_GAP,
        ST_FLUSH,
        ST_DONE
    } feed_state_t;

    // Sentinel the heap is filled with on init: larger than any real record.
    function automatic logic [HEAP_DATA_W-1:0] INIT_DATA();
        return {FLAG_MAX, {(HEAP_DATA_W-2){1'b0}}};
    endfunction

    // Sentinel pushed during flush: smaller than any real record.
    function automatic logic [HEAP_DATA_W-1:0] FLUSH_DATA();
        return {FLAG_MIN, {(HEAP_DATA_W-2){1'b0}}};
    endfunction

    // Flags order MIN < NORMAL < MAX; keys break ties between equal flags.
    function automatic logic [1:0] flag_rank(input logic [1:0] f);
        case (f)
            FLAG_MIN: return 2'd0;
            FLAG_MAX: return 2'd2;
            default:  return 2'd1;
        endcase
    endfunction

    function automatic logic cmp_lt(input logic [HEAP_DATA_W-1:0] a,
                                    input logic [HEAP_DATA_W-1:0] b);
        logic [1:0] ra;
        logic [1:0] rb;
        ra = flag_rank(a[HEAP_DATA_W-1 -: 2]);
        rb = flag_rank(b[HEAP_DATA_W-1 -: 2]);
        if (ra != rb) return ra < rb;
        return a[HEAP_KEY_W-1:0] < b[HEAP_KEY_W-1:0];
    endfunction

    function automatic logic cmp_lte(input logic [HEAP_DATA_W-1:0] a,
                                     input logic [HEAP_DATA_W-1:0] b);
        return !cmp_lt(b, a);
    endfunction

endpackage

// File: rtl/feed_fifo.sv
// Synchronous FIFO with registered read data. Pushes when full and pops when
// empty are dropped. Read data updates only on a pop and holds otherwise.
module feed_fifo
    import heap_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_dout;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_dout;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointers (wrap naturally at power-of-two depth), occupancy and read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/heap_feed_ctrl.sv
// Feeds scored records into the top-K heap: packs them as normal-flag words,
// buffers them, and replays them in bounded bursts separated by idle gaps so
// the heap's overflow FIFOs can drain. Each frame is framed by init and flush.
module heap_feed_ctrl
    import heap_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int KEY_WIDTH    = 4,
    parameter int BUF_DEPTH    = 16,
    parameter int BURST_LEN    = 8,
    parameter int GAP_CYCLES   = 8,
    parameter int INIT_CYCLES  = 64,
    parameter int FLUSH_CYCLES = 136
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_start,
    input  logic                            frame_end,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [KEY_WIDTH-1:0]            s_key,
    input  logic [DATA_WIDTH-2-KEY_WIDTH-1:0] s_payload,
    output logic [DATA_WIDTH-1:0]           heap_din,
    output logic                            heap_en,
    output logic                            heap_init,
    output logic                            heap_flush,
    output logic                            busy,
    output logic                            frame_done,
    output logic [15:0]                     feat_cnt
);

    localparam int CW  = $clog2(BUF_DEPTH) + 1;
    localparam int BCW = $clog2(BURST_LEN + 1);

    feed_state_t           r_state;
    feed_state_t           w_next;
    logic [15:0]           r_wait;
    logic [BCW-1:0]        r_burst_cnt;
    logic                  r_fes;
    logic [15:0]           r_feat_cnt;
    logic                  r_pop_d;
    logic                  r_heap_en;
    logic [DATA_WIDTH-1:0] r_heap_din;
    logic                  r_heap_init;
    logic                  r_heap_flush;
    logic                  r_busy;
    logic                  r_frame_done;

    logic                  w_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last_pop;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_fifo_dout;
    logic [CW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;

    assign w_word  = {FLAG_NORMAL, s_payload, s_key};
    assign w_ready = (r_state inside {ST_INIT, ST_COLLECT, ST_BURST, ST_GAP}) && !w_full;
    assign w_push  = s_valid & w_ready;
    // A burst ends at its length cap, or on the pop that would leave the
    // buffer empty (a simultaneous push keeps it non-empty).
    assign w_last_pop = (r_burst_cnt == BCW'(BURST_LEN - 1)) ||
                        ((w_count == CW'(1)) && !w_push);

    assign s_ready    = w_ready;
    assign heap_din   = r_heap_din;
    assign heap_en    = r_heap_en;
    assign heap_init  = r_heap_init;
    assign heap_flush = r_heap_flush;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign feat_cnt   = r_feat_cnt;

    feed_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_word),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-state and pop decision.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            ST_IDLE:    if (frame_start) w_next = ST_INIT;
            ST_INIT:    if (r_wait == 16'(INIT_CYCLES - 1)) w_next = ST_COLLECT;
            ST_COLLECT: begin
                if (w_count >= CW'(BURST_LEN))        w_next = ST_BURST;
                else if (r_fes && (w_count != '0))    w_next = ST_BURST;
                else if (r_fes)                       w_next = ST_FLUSH;
            end
            ST_BURST: begin
                w_pop = !w_empty;
                if (w_empty || w_last_pop) w_next = ST_GAP;
            end
            ST_GAP:     if (r_wait == 16'(GAP_CYCLES - 1)) w_next = ST_COLLECT;
            ST_FLUSH:   if (r_wait == 16'(FLUSH_CYCLES - 1)) w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // State register plus the per-state wait and burst counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wait      <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)                            r_wait <= '0;
            else if (r_state inside {ST_INIT, ST_GAP, ST_FLUSH}) r_wait <= r_wait + 1'b1;
            if (r_state != ST_BURST) r_burst_cnt <= '0;
            else if (w_pop)          r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    // Frame bookkeeping: frame_end latch and saturating accepted-word count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fes      <= 1'b0;
            r_feat_cnt <= '0;
        end else if (r_state == ST_IDLE && w_next == ST_INIT) begin
            r_fes      <= 1'b0;
            r_feat_cnt <= '0;
        end else begin
            if (frame_end && (r_state inside {ST_INIT, ST_COLLECT, ST_BURST, ST_GAP}))
                r_fes <= 1'b1;
            if (w_push && (r_feat_cnt != 16'hFFFF))
                r_feat_cnt <= r_feat_cnt + 1'b1;
        end
    end

    // Registered heap-side outputs. The popped word appears one cycle after
    // the FIFO read register, so heap_din is zero whenever heap_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pop_d      <= 1'b0;
            r_heap_en    <= 1'b0;
            r_heap_din   <= '0;
            r_heap_init  <= 1'b0;
            r_heap_flush <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_pop_d      <= w_pop;
            r_heap_en    <= r_pop_d;
            r_heap_din   <= r_pop_d ? w_fifo_dout : '0;
            r_heap_init  <= (r_state != ST_INIT)  && (w_next == ST_INIT);
            r_heap_flush <= (r_state != ST_FLUSH) && (w_next == ST_FLUSH);
            r_busy       <= (w_next != ST_IDLE);
            r_frame_done <= (w_next == ST_DONE);
        end
    end

endmodule
